// File: rtl/mm_ctrl_pkg.sv
// Shared types for the matrix-multiply control path.
package mm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    GAP,
    IRQ
  } seq_state_t;

  localparam int IRQ_BIT = 0;

endpackage

// File: rtl/mm_edge_det.sv
// Registered rising-edge detector; the first sample after reset compares against 0.
module mm_edge_det (
  input  logic user_clk,
  input  logic user_resetn,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) din_q <= 1'b0;
    else              din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/mm_job_sequencer.sv
// Job sequencer for the matrix-multiply core: start pulses, batching, timeout, irq handshake.
// States: IDLE wait | START pulse core | RUN job active | GAP inter-job idle | IRQ irq handshake
module mm_job_sequencer
  import mm_ctrl_pkg::*;
#(
  parameter int C_NUM_USR_IRQ = 1,
  parameter int BATCH_W       = 8,
  parameter int CYC_W         = 32,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                     user_clk,
  input  logic                     user_resetn,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic                     cfg_irq_en,
  input  logic [BATCH_W-1:0]       cfg_batch,
  input  logic [CYC_W-1:0]         cfg_timeout,
  output logic                     mm_start,
  input  logic                     mm_finish,
  output logic [C_NUM_USR_IRQ-1:0] usr_irq_req,
  input  logic [C_NUM_USR_IRQ-1:0] usr_irq_ack,
  output logic                     sts_busy,
  output logic                     sts_done,
  output logic                     sts_timeout,
  output logic                     sts_aborted,
  output logic [BATCH_W-1:0]       sts_jobs_done,
  output logic [CYC_W-1:0]         sts_cycles
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t         state, state_d;
  logic               fin_rise;
  logic [BATCH_W-1:0] batch_q, jobs_q;
  logic [CYC_W-1:0]   timeout_q, cycles_q, job_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic               irq_en_q, irq_req_q, done_q, to_q, ab_q;
  logic               ld_cfg, run_cnt, job_fin, set_done, set_to, set_ab;
  logic               gap_ld, irq_set, irq_clr, start_pulse;

  mm_edge_det u_fin_edge (
    .user_clk    (user_clk),
    .user_resetn (user_resetn),
    .din         (mm_finish),
    .rise        (fin_rise)
  );

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) state <= IDLE;
    else              state <= state_d;
  end

  always_comb begin
    state_d     = state;
    ld_cfg      = 1'b0;
    run_cnt     = 1'b0;
    job_fin     = 1'b0;
    set_done    = 1'b0;
    set_to      = 1'b0;
    set_ab      = 1'b0;
    gap_ld      = 1'b0;
    irq_set     = 1'b0;
    irq_clr     = 1'b0;
    start_pulse = 1'b0;
    // Abort outranks finish, timeout and ack in every busy state.
    if (cfg_abort && (state != IDLE)) begin
      state_d = IDLE;
      set_ab  = 1'b1;
      irq_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start && !cfg_abort) begin
            ld_cfg  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          start_pulse = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          run_cnt = 1'b1;
          if (fin_rise) begin
            job_fin = 1'b1;
            if ((jobs_q + BATCH_W'(1)) == batch_q) begin
              set_done = 1'b1;
              state_d  = IRQ;
            end else begin
              gap_ld  = 1'b1;
              state_d = GAP;
            end
          end else if ((timeout_q != '0) && (job_cnt_q == (timeout_q - CYC_W'(1)))) begin
            set_to  = 1'b1;
            state_d = IRQ;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) state_d = START;
        end
        IRQ: begin
          if (!irq_en_q) begin
            state_d = IDLE;
          end else if (!irq_req_q) begin
            irq_set = 1'b1;
          end else if (usr_irq_ack[IRQ_BIT]) begin
            irq_clr = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      batch_q   <= '0;
      timeout_q <= '0;
      irq_en_q  <= 1'b0;
      jobs_q    <= '0;
      cycles_q  <= '0;
      job_cnt_q <= '0;
      gap_cnt_q <= '0;
      irq_req_q <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      ab_q      <= 1'b0;
    end else begin
      if (ld_cfg) begin
        batch_q   <= (cfg_batch == '0) ? BATCH_W'(1) : cfg_batch;
        timeout_q <= cfg_timeout;
        irq_en_q  <= cfg_irq_en;
        jobs_q    <= '0;
        cycles_q  <= '0;
        done_q    <= 1'b0;
        to_q      <= 1'b0;
        ab_q      <= 1'b0;
      end
      if (run_cnt) begin
        if (cycles_q != '1) cycles_q <= cycles_q + CYC_W'(1);
        job_cnt_q <= job_cnt_q + CYC_W'(1);
      end else begin
        job_cnt_q <= '0;
      end
      if (job_fin)  jobs_q <= jobs_q + BATCH_W'(1);
      if (set_done) done_q <= 1'b1;
      if (set_to)   to_q   <= 1'b1;
      if (set_ab)   ab_q   <= 1'b1;
      if (gap_ld)                                gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
      else if ((state == GAP) && (gap_cnt_q != '0)) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
      if (irq_clr)      irq_req_q <= 1'b0;
      else if (irq_set) irq_req_q <= 1'b1;
    end
  end

  assign mm_start      = start_pulse;
  assign sts_busy      = (state != IDLE);
  assign sts_done      = done_q;
  assign sts_timeout   = to_q;
  assign sts_aborted   = ab_q;
  assign sts_jobs_done = jobs_q;
  assign sts_cycles    = cycles_q;

  always_comb begin
    usr_irq_req          = '0;
    usr_irq_req[IRQ_BIT] = irq_req_q & ~cfg_abort;
  end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Randomized bench for mm_job_sequencer against a per-batch event timeline model.
module tb_mm_job_sequencer;

  localparam int GAP  = 2;
  localparam int MAXC = 256;

  logic        user_clk = 1'b0;
  logic        user_resetn;
  logic        cfg_start, cfg_abort, cfg_irq_en;
  logic [7:0]  cfg_batch;
  logic [31:0] cfg_timeout;
  logic        mm_start, mm_finish;
  logic [0:0]  usr_irq_req, usr_irq_ack;
  logic        sts_busy, sts_done, sts_timeout, sts_aborted;
  logic [7:0]  sts_jobs_done;
  logic [31:0] sts_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int dly[4];
  bit e_start[MAXC], e_irq[MAXC], e_busy[MAXC], f_drv[MAXC], a_drv[MAXC], run_c[MAXC], fin_ev[MAXC];

  always #5 user_clk = ~user_clk;

  mm_job_sequencer dut (
    .user_clk      (user_clk),
    .user_resetn   (user_resetn),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_irq_en    (cfg_irq_en),
    .cfg_batch     (cfg_batch),
    .cfg_timeout   (cfg_timeout),
    .mm_start      (mm_start),
    .mm_finish     (mm_finish),
    .usr_irq_req   (usr_irq_req),
    .usr_irq_ack   (usr_irq_ack),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_timeout   (sts_timeout),
    .sts_aborted   (sts_aborted),
    .sts_jobs_done (sts_jobs_done),
    .sts_cycles    (sts_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge user_clk);
    #1;
  endtask

  // Builds the expected timeline of one batch (cycle 0 = cfg_start), then drives and checks it.
  // ka_in: -1 no abort, 0 abort at a random busy cycle, >0 abort at that cycle.
  task automatic run_batch(input int b_cfg, input int t_cfg, input bit irq_en, input bit level,
                           input int ack_wait, input int ka_in, input bit noise);
    int b, s, e, outcome, last, ka, stop, exp_jobs, exp_cyc, nxt;
    b = (b_cfg == 0) ? 1 : b_cfg;
    for (int c = 0; c < MAXC; c++) begin
      e_start[c] = 0; e_irq[c] = 0; e_busy[c] = 0;
      f_drv[c] = 0; a_drv[c] = 0; run_c[c] = 0; fin_ev[c] = 0;
    end
    s = 1; e = 0; outcome = 0;
    for (int j = 0; j < b; j++) begin
      e_start[s] = 1;
      if (t_cfg != 0 && t_cfg < dly[j]) begin
        for (int k = 1; k <= t_cfg; k++) run_c[s+k] = 1;
        e = s + t_cfg;
        outcome = 2;
        break;
      end
      for (int k = 1; k <= dly[j]; k++) run_c[s+k] = 1;
      e = s + dly[j];
      fin_ev[e] = 1;
      nxt = e + GAP + 1;
      if (level) begin
        for (int k = e; k < ((j == b-1) ? MAXC : nxt + 1); k++) f_drv[k] = 1;
      end else begin
        f_drv[e] = 1;
      end
      if (j == b-1) outcome = 1;
      else          s = nxt;
    end
    if (!irq_en) begin
      last = e + 1;
    end else begin
      last = e + 2 + ack_wait;
      for (int k = e + 2; k <= last; k++) e_irq[k] = 1;
      a_drv[last] = 1;
    end
    for (int k = 1; k <= last; k++) e_busy[k] = 1;
    ka = (ka_in == 0) ? int'($urandom_range(last, 1)) : ka_in;
    if (ka > 0) begin
      e_start[ka] = 0;
      e_irq[ka]   = 0;
      for (int k = ka + 1; k < MAXC; k++) begin
        e_start[k] = 0; e_irq[k] = 0; e_busy[k] = 0;
      end
      stop = ka;
    end else begin
      stop = last;
    end

    exp_jobs = 0;
    exp_cyc  = 0;
    for (int c = 0; c <= stop + 2; c++) begin
      cfg_start = (c == 0) || (noise && c >= 2 && c <= stop && $urandom_range(3, 0) == 0);
      cfg_abort = (ka > 0 && c == ka);
      if (c == 0) begin
        cfg_batch   = 8'(b_cfg);
        cfg_timeout = 32'(t_cfg);
        cfg_irq_en  = irq_en;
      end else if (noise) begin
        cfg_batch   = 8'($urandom);
        cfg_timeout = $urandom;
        cfg_irq_en  = 1'($urandom);
      end
      mm_finish      = f_drv[c];
      usr_irq_ack[0] = a_drv[c];
      @(negedge user_clk);
      check($sformatf("mm_start c%0d", c), mm_start, e_start[c]);
      check($sformatf("busy c%0d", c), sts_busy, e_busy[c]);
      check($sformatf("irq_req c%0d", c), usr_irq_req[0], e_irq[c]);
      if (c >= 1) begin
        check($sformatf("jobs_done c%0d", c), sts_jobs_done, exp_jobs);
        check($sformatf("cycles c%0d", c), sts_cycles, exp_cyc);
        check($sformatf("done c%0d", c), sts_done,
              (outcome == 1 && c > e && !(ka > 0 && ka <= e)));
        check($sformatf("timeout c%0d", c), sts_timeout,
              (outcome == 2 && c > e && !(ka > 0 && ka <= e)));
        check($sformatf("aborted c%0d", c), sts_aborted, (ka > 0 && c > ka));
      end
      if (!(ka > 0 && c >= ka)) begin
        exp_jobs += fin_ev[c];
        exp_cyc  += run_c[c];
      end
      next_cycle();
    end
    cfg_start      = 0;
    cfg_abort      = 0;
    mm_finish      = 0;
    usr_irq_ack[0] = 0;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    user_resetn = 0;
    cfg_start   = 0;
    cfg_abort   = 0;
    cfg_irq_en  = 0;
    cfg_batch   = 0;
    cfg_timeout = 0;
    mm_finish   = 1;
    usr_irq_ack = 0;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    check("rst mm_start", mm_start, 0);
    check("rst irq_req", usr_irq_req, 0);
    check("rst busy", sts_busy, 0);
    check("rst done", sts_done, 0);
    check("rst timeout", sts_timeout, 0);
    check("rst aborted", sts_aborted, 0);
    check("rst jobs_done", sts_jobs_done, 0);
    check("rst cycles", sts_cycles, 0);
    @(posedge user_clk);
    #1;
    user_resetn = 1;
    next_cycle();

    // Finish held high since reset: no edge, so the batch never completes; abort it.
    for (int c = 0; c <= 13; c++) begin
      cfg_start   = (c == 0);
      cfg_abort   = (c == 12);
      cfg_batch   = 2;
      cfg_timeout = 0;
      cfg_irq_en  = 0;
      @(negedge user_clk);
      check($sformatf("hi_fin mm_start c%0d", c), mm_start, (c == 1));
      check($sformatf("hi_fin busy c%0d", c), sts_busy, (c >= 1 && c <= 12));
      if (c >= 1) begin
        check($sformatf("hi_fin jobs c%0d", c), sts_jobs_done, 0);
        check($sformatf("hi_fin done c%0d", c), sts_done, 0);
      end
      if (c == 13) begin
        check("hi_fin aborted", sts_aborted, 1);
        check("hi_fin cycles", sts_cycles, 10);
      end
      next_cycle();
    end
    cfg_start = 0;
    cfg_abort = 0;
    mm_finish = 0;
    next_cycle();
    next_cycle();

    // Start and abort together in IDLE: abort wins.
    cfg_start = 1;
    cfg_abort = 1;
    cfg_batch = 1;
    @(negedge user_clk);
    check("idle_abort mm_start", mm_start, 0);
    next_cycle();
    cfg_start = 0;
    cfg_abort = 0;
    @(negedge user_clk);
    check("idle_abort busy", sts_busy, 0);
    check("idle_abort mm_start2", mm_start, 0);
    next_cycle();

    dly = '{10, 1, 1, 1};
    run_batch(1, 0, 0, 0, 0, -1, 0);
    dly = '{4, 6, 3, 1};
    run_batch(3, 0, 1, 1, 3, -1, 1);
    dly = '{50, 1, 1, 1};
    run_batch(1, 5, 1, 0, 2, -1, 0);
    dly = '{4, 6, 6, 1};
    run_batch(3, 0, 0, 0, 0, 10, 0);
    dly = '{3, 1, 1, 1};
    run_batch(1, 0, 1, 0, 4, 7, 0);
    dly = '{5, 1, 1, 1};
    run_batch(1, 5, 1, 0, 0, -1, 0);
    dly = '{1, 1, 1, 1};
    run_batch(0, 1, 0, 0, 0, -1, 0);

    // Reset pulse in the middle of RUN.
    cfg_start   = 1;
    cfg_batch   = 1;
    cfg_timeout = 0;
    cfg_irq_en  = 1;
    next_cycle();
    cfg_start = 0;
    repeat (3) next_cycle();
    @(negedge user_clk);
    check("mid_rst pre busy", sts_busy, 1);
    check("mid_rst pre cycles", sts_cycles, 2);
    #2;
    user_resetn = 0;
    #1;
    check("mid_rst busy", sts_busy, 0);
    check("mid_rst mm_start", mm_start, 0);
    check("mid_rst cycles", sts_cycles, 0);
    check("mid_rst jobs", sts_jobs_done, 0);
    check("mid_rst irq", usr_irq_req, 0);
    check("mid_rst done", sts_done, 0);
    @(posedge user_clk);
    #1;
    user_resetn = 1;
    next_cycle();

    for (int n = 0; n < 40; n++) begin
      bit lvl;
      int b, t, ka;
      lvl = 1'($urandom);
      b   = int'($urandom_range(4, 0));
      t   = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      for (int j = 0; j < 4; j++)
        dly[j] = lvl ? int'($urandom_range(12, 2)) : int'($urandom_range(12, 1));
      ka = ($urandom_range(3, 0) == 0) ? 0 : -1;
      run_batch(b, t, 1'($urandom), lvl, int'($urandom_range(4, 0)), ka, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
